intpol_ctrl_fsm_p: RTL and testbench

Parametrised control FSM for the 2nd-order interpolator datapath. It generalises the fixed interpolation controller: the interpolation ratio and the config-word count are runtime inputs, and the write phase is sequenced over N_CH output channels. Counters that were previously external are now internal. The block sits between the register/start interface and the interpolator datapath, input FIFO and output FIFO.

---
 rtl/intpol_ctrl_fsm_p_if.sv | 54 +++++
 rtl/intpol_ctrl_fsm_p.sv | 232 +++++++++++++++++++++++
 tb/tb_intpol_ctrl_fsm_p.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/intpol_ctrl_fsm_p_if.sv
// Start/config, FIFO status and datapath strobe bundle between the register side and the interpolator control FSM.
// When INTPOL_WDOG_EN is defined the bundle also carries the sticky timeout flag.
interface intpol_ctrl_fsm_p_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CH_W   = 1
);
  logic              start;
  logic              mode;
  logic              bypass;
  logic [CNT_W-1:0]  ratio;
  logic [ADDR_W-1:0] n_addr;
  logic              Afull;
  logic              Empty;

  logic              busy;
  logic              done;
  logic              clear;
  logic              read_en;
  logic [ADDR_W-1:0] addr;
  logic              op_1;
  logic              ld_p1_xi;
  logic              sel_mult;
  logic              write_en;
  logic [CH_W-1:0]   ch_sel;
  logic              en_sum;
  logic              en_stream;
  logic              stop_empty;
  logic              stop_Afull;
  logic              frame_tick;
`ifdef INTPOL_WDOG_EN
  logic              timeout;
`endif

  // Register/start side: drives configuration and FIFO status, observes the strobes.
  modport master (
`ifdef INTPOL_WDOG_EN
    input  timeout,
`endif
    output start, mode, bypass, ratio, n_addr, Afull, Empty,
    input  busy, done, clear, read_en, addr, op_1, ld_p1_xi, sel_mult,
           write_en, ch_sel, en_sum, en_stream, stop_empty, stop_Afull, frame_tick
  );

  // Control FSM side.
  modport slave (
`ifdef INTPOL_WDOG_EN
    output timeout,
`endif
    input  start, mode, bypass, ratio, n_addr, Afull, Empty,
    output busy, done, clear, read_en, addr, op_1, ld_p1_xi, sel_mult,
           write_en, ch_sel, en_sum, en_stream, stop_empty, stop_Afull, frame_tick
  );
endinterface

// File: rtl/intpol_ctrl_fsm_p.sv
// Control FSM for the 2nd-order interpolator: config load, per-sample CALC/WRITE over N_CH channels, streaming refill.
// Optional WAIT_IN watchdog with sticky timeout flag is enabled by defining INTPOL_WDOG_EN.
module intpol_ctrl_fsm_p #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CH_W   = 1
`ifdef INTPOL_WDOG_EN
  , parameter int unsigned WDOG_W = 10
`endif
) (
  input logic                clk,
  input logic                rstn,
  intpol_ctrl_fsm_p_if.slave bus
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PRIME, S_CALC, S_WRITE, S_END,
    S_WAIT_IN, S_FETCH, S_BYP_DONE, S_BYP_STRM, S_CLEAR
  } state_t;

  state_t            r_state,   w_state_nx;
  logic [ADDR_W-1:0] r_addr,    w_addr_nx;
  logic [CNT_W-1:0]  r_k,       w_k_nx;
  logic [CH_W-1:0]   r_ch,      w_ch_nx;
  logic [CNT_W-1:0]  r_ratio_q, w_ratio_nx;
  logic [ADDR_W-1:0] r_naddr_q, w_naddr_nx;
`ifdef INTPOL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;
  logic [WDOG_W-1:0] r_wdog,    w_wdog_nx;
  logic              r_timeout, w_timeout_nx;
`endif

  logic              w_busy, w_done, w_read_en, w_op_1, w_ld_p1_xi, w_sel_mult;
  logic              w_write_en, w_en_sum, w_en_stream, w_stop_empty, w_stop_Afull;
  logic              w_frame_tick;
  logic [ADDR_W-1:0] w_addr;
  logic [CH_W-1:0]   w_ch_sel;

  logic              w_abort;
  logic [CNT_W-1:0]  w_ratio_lat;
  logic [ADDR_W-1:0] w_naddr_lat;

  // Zero ratio / word count are promoted to 1 so the terminal compares never underflow.
  assign w_ratio_lat = (bus.ratio  == '0) ? CNT_W'(1)  : bus.ratio;
  assign w_naddr_lat = (bus.n_addr == '0) ? ADDR_W'(1) : bus.n_addr;
  assign w_abort     = bus.start && (r_state != S_IDLE) && (r_state != S_CLEAR);

  // Next-state, counter update and output decode.
  always_comb begin
    w_state_nx   = r_state;
    w_addr_nx    = r_addr;
    w_k_nx       = r_k;
    w_ch_nx      = r_ch;
    w_ratio_nx   = r_ratio_q;
    w_naddr_nx   = r_naddr_q;
`ifdef INTPOL_WDOG_EN
    w_wdog_nx    = '0;
    w_timeout_nx = r_timeout;
`endif
    w_busy       = (r_state != S_IDLE);
    w_done       = 1'b0;
    w_read_en    = 1'b0;
    w_addr       = '0;
    w_op_1       = 1'b0;
    w_ld_p1_xi   = 1'b0;
    w_sel_mult   = 1'b0;
    w_write_en   = 1'b0;
    w_ch_sel     = '0;
    w_en_sum     = 1'b0;
    w_en_stream  = 1'b0;
    w_stop_empty = 1'b0;
    w_stop_Afull = 1'b0;
    w_frame_tick = 1'b0;

    // A restart request wins over everything: the current cycle issues no strobes.
    if (w_abort) begin
      w_state_nx = S_CLEAR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_ratio_nx = w_ratio_lat;
            w_naddr_nx = w_naddr_lat;
            w_addr_nx  = '0;
`ifdef INTPOL_WDOG_EN
            w_timeout_nx = 1'b0;
`endif
            w_state_nx = (bus.bypass && bus.mode) ? S_BYP_STRM : S_LOAD;
          end
        end
        S_LOAD: begin
          w_read_en = 1'b1;
          w_addr    = r_addr;
          if (r_addr == r_naddr_q - ADDR_W'(1)) begin
            w_addr_nx  = '0;
            w_state_nx = bus.bypass ? S_BYP_DONE : S_PRIME;
          end else begin
            w_addr_nx = r_addr + ADDR_W'(1);
          end
        end
        S_PRIME: begin
          w_op_1     = 1'b1;
          w_k_nx     = '0;
          w_ch_nx    = '0;
          w_state_nx = S_CALC;
        end
        S_CALC: begin
          w_ld_p1_xi = 1'b1;
          w_state_nx = S_WRITE;
        end
        S_WRITE: begin
          w_sel_mult = 1'b1;
          w_ch_sel   = r_ch;
          if (bus.mode && bus.Afull) begin
            w_stop_Afull = 1'b1;
          end else begin
            w_write_en = 1'b1;
            if (r_ch == CH_LAST) begin
              w_ch_nx = '0;
              if (r_k == r_ratio_q - CNT_W'(1)) begin
                w_state_nx = S_END;
              end else begin
                w_en_sum   = 1'b1;
                w_k_nx     = r_k + CNT_W'(1);
                w_state_nx = S_CALC;
              end
            end else begin
              w_ch_nx = r_ch + CH_W'(1);
            end
          end
        end
        S_END: begin
          if (bus.mode) begin
            w_frame_tick = 1'b1;
            w_state_nx   = S_WAIT_IN;
          end else begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
        S_WAIT_IN: begin
          w_read_en    = 1'b1;
          w_stop_empty = bus.Empty;
          if (!bus.Empty) begin
            w_state_nx = S_FETCH;
          end
`ifdef INTPOL_WDOG_EN
          else if (r_wdog == WDOG_MAX) begin
            w_done       = 1'b1;
            w_timeout_nx = 1'b1;
            w_state_nx   = S_IDLE;
          end else begin
            w_wdog_nx = r_wdog + WDOG_W'(1);
          end
`endif
        end
        S_FETCH: begin
          w_en_stream = 1'b1;
          w_state_nx  = S_PRIME;
        end
        S_BYP_DONE: begin
          w_done     = 1'b1;
          w_state_nx = S_IDLE;
        end
        S_BYP_STRM: begin
          w_read_en    = 1'b1;
          w_stop_empty = bus.Empty;
          w_stop_Afull = bus.Afull;
        end
        S_CLEAR: begin
          if (!bus.start) begin
            w_ratio_nx = w_ratio_lat;
            w_naddr_nx = w_naddr_lat;
            w_addr_nx  = '0;
            w_state_nx = S_LOAD;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_k       <= '0;
      r_ch      <= '0;
      r_ratio_q <= '0;
      r_naddr_q <= '0;
`ifdef INTPOL_WDOG_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_addr    <= w_addr_nx;
      r_k       <= w_k_nx;
      r_ch      <= w_ch_nx;
      r_ratio_q <= w_ratio_nx;
      r_naddr_q <= w_naddr_nx;
`ifdef INTPOL_WDOG_EN
      r_wdog    <= w_wdog_nx;
      r_timeout <= w_timeout_nx;
`endif
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.clear      = bus.start | w_done;
  assign bus.read_en    = w_read_en;
  assign bus.addr       = w_addr;
  assign bus.op_1       = w_op_1;
  assign bus.ld_p1_xi   = w_ld_p1_xi;
  assign bus.sel_mult   = w_sel_mult;
  assign bus.write_en   = w_write_en;
  assign bus.ch_sel     = w_ch_sel;
  assign bus.en_sum     = w_en_sum;
  assign bus.en_stream  = w_en_stream;
  assign bus.stop_empty = w_stop_empty;
  assign bus.stop_Afull = w_stop_Afull;
  assign bus.frame_tick = w_frame_tick;
`ifdef INTPOL_WDOG_EN
  assign bus.timeout    = r_timeout;
`endif

endmodule

// File: tb/tb_intpol_ctrl_fsm_p.sv
// Directed bench for intpol_ctrl_fsm_p: one-shot, streaming stalls, zero config, abort/restart, bypass and reset.
module tb_intpol_ctrl_fsm_p;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  intpol_ctrl_fsm_p_if #(.ADDR_W(4), .CNT_W(8), .CH_W(1)) bus ();

  intpol_ctrl_fsm_p #(.ADDR_W(4), .CNT_W(8), .N_CH(2), .CH_W(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  wire [17:0] w_outs = {bus.busy, bus.done, bus.clear, bus.read_en, bus.addr, bus.op_1,
                        bus.ld_p1_xi, bus.sel_mult, bus.write_en, bus.ch_sel, bus.en_sum,
                        bus.en_stream, bus.stop_empty, bus.stop_Afull, bus.frame_tick};

  int n_checks = 0;
  int n_pass   = 0;

  int cyc_n, cnt_rd, cnt_ld, cnt_wr, cnt_wr_st, cnt_sum, cnt_op1, cnt_stream, cnt_ftick;
  int cnt_done, cnt_clear, cnt_safull, cnt_sempty;
  int done_cyc, ftick_cyc, stream_cyc, op1_cyc;
  logic [15:0] addr_seq, ch_seq;
  logic [7:0]  stop_seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_stats();
    cyc_n = 0; cnt_rd = 0; cnt_ld = 0; cnt_wr = 0; cnt_wr_st = 0; cnt_sum = 0; cnt_op1 = 0;
    cnt_stream = 0; cnt_ftick = 0; cnt_done = 0; cnt_clear = 0; cnt_safull = 0; cnt_sempty = 0;
    done_cyc = -1; ftick_cyc = -1; stream_cyc = -1; op1_cyc = -1;
    addr_seq = '0; ch_seq = '0;
  endtask

  // One clock cycle: apply inputs after the edge, then sample the combinational outputs.
  task automatic cyc(input logic st, input logic af, input logic em);
    @(posedge clk);
    #2;
    bus.start = st; bus.Afull = af; bus.Empty = em;
    #1;
    if (bus.read_en)    begin cnt_rd++; addr_seq = {addr_seq[11:0], bus.addr}; end
    if (bus.ld_p1_xi)   cnt_ld++;
    if (bus.write_en)   begin cnt_wr++; ch_seq = {ch_seq[14:0], bus.ch_sel}; end
    if (bus.write_en && bus.start) cnt_wr_st++;
    if (bus.en_sum)     cnt_sum++;
    if (bus.op_1)       begin cnt_op1++; op1_cyc = cyc_n; end
    if (bus.en_stream)  begin cnt_stream++; stream_cyc = cyc_n; end
    if (bus.frame_tick) begin cnt_ftick++; ftick_cyc = cyc_n; end
    if (bus.done)       begin cnt_done++; done_cyc = cyc_n; end
    if (bus.clear)      cnt_clear++;
    if (bus.stop_Afull) cnt_safull++;
    if (bus.stop_empty) cnt_sempty++;
    cyc_n++;
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.bypass = 1'b0; bus.ratio = '0; bus.n_addr = '0;
    bus.Afull = 1'b0; bus.Empty = 1'b0;
    #3;
    chk("rst_outs", 32'(w_outs), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    #9 rstn = 1'b1;

    // One-shot: ratio 3, 4 config words, done 15 cycles after start.
    bus.ratio = 8'd3; bus.n_addr = 4'd4;
    clr_stats();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("os_rd",     32'(cnt_rd),    32'd4);
    chk("os_addr",   32'(addr_seq),  32'h0123);
    chk("os_ld",     32'(cnt_ld),    32'd3);
    chk("os_wr",     32'(cnt_wr),    32'd6);
    chk("os_ch",     32'(ch_seq),    32'h0015);
    chk("os_sum",    32'(cnt_sum),   32'd2);
    chk("os_op1",    32'(op1_cyc),   32'd5);
    chk("os_done_c", 32'(done_cyc),  32'd15);
    chk("os_done_n", 32'(cnt_done),  32'd1);
    chk("os_clear",  32'(cnt_clear), 32'd2);
    chk("os_busy",   32'(bus.busy),  32'h0);

    // Streaming, ratio 2, Afull held for 5 cycles in the first WRITE.
    bus.mode = 1'b1; bus.ratio = 8'd2; bus.n_addr = 4'd1;
    clr_stats();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("st_safull", 32'(cnt_safull), 32'd5);
    chk("st_wr",     32'(cnt_wr),     32'd4);
    chk("st_ch",     32'(ch_seq),     32'h0005);
    chk("st_sum",    32'(cnt_sum),    32'd1);
    chk("st_ftick",  32'(ftick_cyc),  32'd14);
    chk("st_ftick_n",32'(cnt_ftick),  32'd1);
    chk("st_done",   32'(cnt_done),   32'd0);

    // WAIT_IN with Empty for 7 cycles, then refill.
    clr_stats();
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("wi_sempty", 32'(cnt_sempty), 32'd7);
    chk("wi_rd",     32'(cnt_rd),     32'd8);
    chk("wi_strm_n", 32'(cnt_stream), 32'd1);
    chk("wi_strm_c", 32'(stream_cyc), 32'd8);
    chk("wi_op1",    32'(op1_cyc),    32'd9);

    // Abort mid-WRITE for 3 cycles, restart with zero ratio/n_addr in one-shot mode.
    clr_stats();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    bus.mode = 1'b0; bus.ratio = '0; bus.n_addr = '0;
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    chk("ab_wr",     32'(cnt_wr),    32'd3);
    chk("ab_wr_st",  32'(cnt_wr_st), 32'd0);
    chk("ab_ch",     32'(ch_seq),    32'h0001);
    chk("ab_clear",  32'(cnt_clear), 32'd4);
    chk("ab_rd",     32'(cnt_rd),    32'd1);
    chk("ab_ld",     32'(cnt_ld),    32'd2);
    chk("ab_done",   32'(done_cyc),  32'd11);
    chk("ab_busy",   32'(bus.busy),  32'h0);

    // Zero ratio/n_addr from IDLE behave as 1/1.
    clr_stats();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    chk("z_rd",   32'(cnt_rd),   32'd1);
    chk("z_wr",   32'(cnt_wr),   32'd2);
    chk("z_done", 32'(done_cyc), 32'd6);

    // Bypass, one-shot: config load then done, no writes.
    bus.bypass = 1'b1; bus.n_addr = 4'd3;
    clr_stats();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    chk("bo_rd",   32'(cnt_rd),   32'd3);
    chk("bo_addr", 32'(addr_seq), 32'h0012);
    chk("bo_wr",   32'(cnt_wr),   32'd0);
    chk("bo_done", 32'(done_cyc), 32'd4);

    // Bypass, streaming: stall flags follow the FIFO status, then abort and exit.
    bus.mode = 1'b1;
    clr_stats();
    stop_seq = '0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); stop_seq = {stop_seq[5:0], bus.stop_empty, bus.stop_Afull};
    cyc(1'b0, 1'b1, 1'b0); stop_seq = {stop_seq[5:0], bus.stop_empty, bus.stop_Afull};
    cyc(1'b0, 1'b1, 1'b1); stop_seq = {stop_seq[5:0], bus.stop_empty, bus.stop_Afull};
    cyc(1'b0, 1'b0, 1'b0); stop_seq = {stop_seq[5:0], bus.stop_empty, bus.stop_Afull};
    chk("bs_stop", 32'(stop_seq), 32'h9C);
    chk("bs_busy", 32'(bus.busy), 32'h1);
    bus.n_addr = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("bs_rd",   32'(cnt_rd),   32'd5);
    chk("bs_wr",   32'(cnt_wr),   32'd0);
    chk("bs_done", 32'(done_cyc), 32'd8);
    chk("bs_idle", 32'(bus.busy), 32'h0);

    // Asynchronous reset mid-operation returns to IDLE without a done pulse.
    bus.mode = 1'b0; bus.bypass = 1'b0; bus.ratio = 8'd3; bus.n_addr = 4'd4;
    clr_stats();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    chk("rs_pre_busy", 32'(bus.busy), 32'h1);
    #1 rstn = 1'b0;
    #1;
    chk("rs_outs", 32'(w_outs), 32'h0);
    #1 rstn = 1'b1;
    clr_stats();
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("rs_done", 32'(cnt_done), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
